// File: rtl/nios2_debug_jtag_scan_master.sv
// Virtual-JTAG scan master for the Nios II debug slave: runs one IR/DR scan per
// command by driving the vJTAG state strobes and returns the captured TDO word.
module nios2_debug_jtag_scan_master #(
  parameter int DR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_DIV    = 2,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vj_tck,
  output logic                vj_tdi,
  input  logic                vj_tdo,
  output logic [IR_WIDTH-1:0] vj_ir_in,
  output logic                vj_uir,
  output logic                vj_cdr,
  output logic                vj_sdr,
  output logic                vj_udr,
  output logic                vj_rti
);

  localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DIV_W   = $clog2(2 * TCK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * TCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(TCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(TCK_DIV);
  localparam logic [CNT_W-1:0] SDR_LAST = CNT_W'(DR_WIDTH - 1);
  localparam logic [CNT_W-1:0] RTI_LAST = CNT_W'(RTI_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UIR  = 3'd1,
    S_CDR  = 3'd2,
    S_SDR  = 3'd3,
    S_UDR  = 3'd4,
    S_RTI  = 3'd5,
    S_DONE = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IR_WIDTH-1:0] last_ir_q, last_ir_d;
  logic                ir_known_q, ir_known_d;
  logic [DR_WIDTH-1:0] payload_q, payload_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                tck_q, tck_d;
  logic                tdi_q, tdi_d;
  logic                uir_q, uir_d;
  logic                cdr_q, cdr_d;
  logic                sdr_q, sdr_d;
  logic                udr_q, udr_d;
  logic                rti_q, rti_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                tck_end_d;
  logic                scan_d;

  // Next-state logic; all outputs are derived from the next state so they leave registers.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    last_ir_d  = last_ir_q;
    ir_known_d = ir_known_q;
    payload_d  = payload_q;
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;
    tck_end_d  = (div_q == DIV_LAST);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          payload_d = cmd_data;
          div_d     = '0;
          cnt_d     = '0;
          if (!ir_known_q || (cmd_ir != last_ir_q)) begin
            state_d    = S_UIR;
            last_ir_d  = cmd_ir;
            ir_known_d = 1'b1;
          end else begin
            state_d = S_CDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        div_d = tck_end_d ? '0 : div_q + DIV_W'(1);
        // TDO is taken on the edge that raises TCK.
        if ((state_q == S_SDR) && (div_q == DIV_RISE)) begin
          cap_d = {vj_tdo, cap_q[DR_WIDTH-1:1]};
        end else begin
          cap_d = cap_q;
        end
        if (tck_end_d) begin
          case (state_q)
            S_UIR: state_d = S_CDR;
            S_CDR: begin
              state_d = S_SDR;
              cnt_d   = '0;
            end
            S_SDR: begin
              payload_d = {1'b0, payload_q[DR_WIDTH-1:1]};
              if (cnt_q == SDR_LAST) begin
                state_d = S_UDR;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
            S_UDR: begin
              state_d = S_RTI;
              cnt_d   = '0;
            end
            S_RTI: begin
              if (cnt_q == RTI_LAST) begin
                state_d    = S_DONE;
                rsp_data_d = cap_q;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = state_q;
        end
      end
    endcase

    scan_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    tck_d       = scan_d && (div_d >= DIV_HIGH);
    tdi_d       = (state_d == S_SDR) ? payload_d[0] : 1'b0;
    uir_d       = (state_d == S_UIR);
    cdr_d       = (state_d == S_CDR);
    sdr_d       = (state_d == S_SDR);
    udr_d       = (state_d == S_UDR);
    rti_d       = !scan_d || (state_d == S_RTI);
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      cnt_q       <= '0;
      last_ir_q   <= '0;
      ir_known_q  <= 1'b0;
      payload_q   <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      tck_q       <= 1'b0;
      tdi_q       <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b1;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      last_ir_q   <= last_ir_d;
      ir_known_q  <= ir_known_d;
      payload_q   <= payload_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      tck_q       <= tck_d;
      tdi_q       <= tdi_d;
      uir_q       <= uir_d;
      cdr_q       <= cdr_d;
      sdr_q       <= sdr_d;
      udr_q       <= udr_d;
      rti_q       <= rti_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign vj_tck    = tck_q;
  assign vj_tdi    = tdi_q;
  assign vj_ir_in  = last_ir_q;
  assign vj_uir    = uir_q;
  assign vj_cdr    = cdr_q;
  assign vj_sdr    = sdr_q;
  assign vj_udr    = udr_q;
  assign vj_rti    = rti_q;

endmodule

// File: tb/tb_nios2_debug_jtag_scan_master.sv
// Bench for the vJTAG scan master: default-parameter instance with a loopback /
// fixed-word slave model, plus a minimal TCK_DIV=1, DR_WIDTH=2 instance.
module tb_nios2_debug_jtag_scan_master;

  localparam int DW = 38;
  localparam int TD = 2;
  localparam int RC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic          reset_n = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic          cmd_ready, rsp_valid, vj_tck, vj_tdi, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti;
  logic          vj_tdo = 1'b0;
  logic [1:0]    cmd_ir = 2'b00, vj_ir_in;
  logic [DW-1:0] cmd_data = '0, rsp_data;

  nios2_debug_jtag_scan_master dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .vj_tck(vj_tck), .vj_tdi(vj_tdi), .vj_tdo(vj_tdo),
    .vj_ir_in(vj_ir_in), .vj_uir(vj_uir), .vj_cdr(vj_cdr), .vj_sdr(vj_sdr),
    .vj_udr(vj_udr), .vj_rti(vj_rti)
  );

  logic       s_reset_n = 1'b0, s_cmd_valid = 1'b0, s_rsp_ready = 1'b0;
  logic       s_cmd_ready, s_rsp_valid, s_tck, s_tdi, s_uir, s_cdr, s_sdr, s_udr, s_rti;
  logic       s_tdo = 1'b0;
  logic [1:0] s_cmd_ir = 2'b00, s_ir_in, s_cmd_data = 2'b00, s_rsp_data;
  logic [1:0] s_tdi_log = 2'b00;

  nios2_debug_jtag_scan_master #(.DR_WIDTH(2), .IR_WIDTH(2), .TCK_DIV(1), .RTI_CYCLES(1)) dut_s (
    .clk(clk), .reset_n(s_reset_n), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_ir(s_cmd_ir), .cmd_data(s_cmd_data), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_data(s_rsp_data), .vj_tck(s_tck), .vj_tdi(s_tdi), .vj_tdo(s_tdo),
    .vj_ir_in(s_ir_in), .vj_uir(s_uir), .vj_cdr(s_cdr), .vj_sdr(s_sdr),
    .vj_udr(s_udr), .vj_rti(s_rti)
  );

  // Slave: loopback (TDO = previous TDI, 0 first) or a fixed word shifted out LSB first.
  logic          sl_fixed = 1'b0;
  logic [DW-1:0] sl_word = '0, sl_shift = '0, sl_tdi_log = '0;
  int            sl_cnt = 0;
  always @(posedge vj_tck) begin
    if (vj_cdr) begin
      sl_cnt   <= 0;
      vj_tdo   <= sl_fixed ? sl_word[0] : 1'b0;
      sl_shift <= {1'b0, sl_word[DW-1:1]};
    end else if (vj_sdr) begin
      sl_cnt     <= sl_cnt + 1;
      sl_tdi_log <= {vj_tdi, sl_tdi_log[DW-1:1]};
      vj_tdo     <= sl_fixed ? sl_shift[0] : vj_tdi;
      sl_shift   <= {1'b0, sl_shift[DW-1:1]};
    end
  end

  // Small-instance slave: loopback with TDO preset to 1 at capture.
  always @(posedge s_tck) begin
    if (s_cdr) begin
      s_tdo <= 1'b1;
    end else if (s_sdr) begin
      s_tdo     <= s_tdi;
      s_tdi_log <= {s_tdi, s_tdi_log[1]};
    end
  end

  logic [1:0] m_last_ir = 2'b00;
  logic       m_ir_known = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [1:0] ir, input logic [DW-1:0] data,
                          input logic fixed, input logic [DW-1:0] word, input int hold);
    int n, lat, exp_lat, uir_clks, rti_clks, onehot_bad, ir_bad, rdy_bad, stable_bad;
    logic exp_uir;
    logic [DW-1:0] exp_rsp;
    exp_uir = !m_ir_known || (ir != m_last_ir);
    exp_lat = 2 * TD * (DW + 2 + RC + (exp_uir ? 1 : 0));
    exp_rsp = fixed ? word : {data[DW-2:0], 1'b0};
    sl_fixed = fixed;
    sl_word = word;
    cmd_ir = ir;
    cmd_data = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    check("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
    lat = 0; uir_clks = 0; rti_clks = 0; onehot_bad = 0; ir_bad = 0; rdy_bad = 0;
    while (!rsp_valid && lat < 1000) begin
      uir_clks += int'(vj_uir);
      rti_clks += int'(vj_rti);
      if ($countones({vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti}) != 1) onehot_bad++;
      if (vj_ir_in !== ir) ir_bad++;
      if (cmd_ready !== 1'b0) rdy_bad++;
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("uir_clks", 64'(uir_clks), exp_uir ? 64'(2 * TD) : 64'd0);
    check("rti_clks", 64'(rti_clks), 64'(2 * TD * RC));
    check("strobe_onehot", 64'(onehot_bad), 64'd0);
    check("ir_in_stable", 64'(ir_bad), 64'd0);
    check("cmd_ready_busy", 64'(rdy_bad), 64'd0);
    check("sdr_bits", 64'(sl_cnt), 64'(DW));
    check("tdi_sequence", 64'(sl_tdi_log), 64'(data));
    check("rsp_data", 64'(rsp_data), 64'(exp_rsp));
    check("done_rti_tck", {62'd0, vj_rti, vj_tck}, 64'd2);
    stable_bad = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!rsp_valid || rsp_data !== exp_rsp || cmd_ready || vj_tck || vj_ir_in !== ir) stable_bad++;
    end
    check("hold_stable", 64'(stable_bad), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("cmd_ready_after_rsp", {63'd0, cmd_ready}, 64'd1);
    check("rsp_valid_cleared", {63'd0, rsp_valid}, 64'd0);
    m_last_ir = ir;
    m_ir_known = 1'b1;
  endtask

  initial begin
    logic [63:0] r64;
    logic [DW-1:0] rdata;
    int n, lat, c_uir, c_cdr, c_sdr, c_udr, c_rti, s_bad;

    // Reset state of both instances.
    repeat (3) tick();
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_strobes", {57'd0, vj_tck, vj_tdi, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti}, 64'd1);
    check("rst_ir_rsp", {63'd0, (vj_ir_in == 2'b00) && !rsp_valid && (rsp_data == '0)}, 64'd1);
    reset_n = 1'b1;
    s_reset_n = 1'b1;
    tick();
    check("cmd_ready_release", {63'd0, cmd_ready}, 64'd1);

    // rsp_ready without rsp_valid is ignored.
    rsp_ready = 1'b1;
    repeat (3) tick();
    rsp_ready = 1'b0;
    check("stray_rsp_ready", {62'd0, cmd_ready, rsp_valid}, 64'd2);

    run_scan(2'b01, 38'h2A_AAAA_AAAA, 1'b0, '0, 0);
    r64 = {$urandom(), $urandom()};
    run_scan(2'b01, r64[DW-1:0], 1'b0, '0, 0);
    r64 = {$urandom(), $urandom()};
    run_scan(2'($urandom_range(0, 3)), r64[DW-1:0], 1'b1, 38'h3F_0000_0001, 50);
    for (int k = 0; k < 3; k++) begin
      r64 = {$urandom(), $urandom()};
      rdata = r64[DW-1:0];
      r64 = {$urandom(), $urandom()};
      run_scan(2'($urandom_range(0, 3)), rdata, 1'($urandom_range(0, 1)), r64[DW-1:0],
               int'($urandom_range(0, 5)));
    end

    // Reset pulse in the middle of the shift abandons the scan and forgets the IR.
    run_scan(2'b01, 38'h00_1234_5678, 1'b0, '0, 0);
    cmd_ir = 2'b01;
    cmd_data = 38'h15_5555_5555;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!(vj_sdr && sl_cnt >= 20) && n < 1000) begin tick(); n++; end
    check("reach_sdr_bit20", {63'd0, vj_sdr && (sl_cnt == 20)}, 64'd1);
    reset_n = 1'b0;
    tick();
    check("midrst_strobes", {57'd0, vj_tck, vj_tdi, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti}, 64'd1);
    check("midrst_ready_rsp", {62'd0, cmd_ready, rsp_valid}, 64'd0);
    check("midrst_ir_data", {63'd0, (vj_ir_in == 2'b00) && (rsp_data == '0)}, 64'd1);
    reset_n = 1'b1;
    m_ir_known = 1'b0;
    tick();
    check("midrst_release_ready", {62'd0, cmd_ready, rsp_valid}, 64'd2);
    run_scan(2'b01, 38'h2A_AAAA_AAAA, 1'b0, '0, 2);

    // Minimal instance: TCK_DIV=1, RTI_CYCLES=1, DR_WIDTH=2.
    s_cmd_ir = 2'b10;
    s_cmd_data = 2'b10;
    s_cmd_valid = 1'b1;
    n = 0;
    while (!s_cmd_ready && n < 100) begin tick(); n++; end
    tick();
    s_cmd_valid = 1'b0;
    lat = 0; c_uir = 0; c_cdr = 0; c_sdr = 0; c_udr = 0; c_rti = 0; s_bad = 0;
    while (!s_rsp_valid && lat < 200) begin
      c_uir += int'(s_uir);
      c_cdr += int'(s_cdr);
      c_sdr += int'(s_sdr);
      c_udr += int'(s_udr);
      c_rti += int'(s_rti);
      if ($countones({s_uir, s_cdr, s_sdr, s_udr, s_rti}) != 1) s_bad++;
      tick();
      lat++;
    end
    check("s_latency", 64'(lat), 64'd12);
    check("s_widths", {44'd0, 4'(c_uir), 4'(c_cdr), 4'(c_sdr), 4'(c_udr), 4'(c_rti)}, 64'h2_2422);
    check("s_onehot", 64'(s_bad), 64'd0);
    check("s_tdi_seq", {62'd0, s_tdi_log}, 64'd2);
    check("s_rsp_data", {62'd0, s_rsp_data}, 64'd1);
    check("s_ir_in", {62'd0, s_ir_in}, 64'd2);
    s_rsp_ready = 1'b1;
    tick();
    s_rsp_ready = 1'b0;
    check("s_ready_after_rsp", {62'd0, s_cmd_ready, s_rsp_valid}, 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
